// File: rtl/twoscomp_seq_pkg.sv
// Shared definitions for the twoscomp_seq block.
//   state_t   : controller state encoding (IDLE, CLR, SHIFT, DONE)
//   WIDTH_DEF : default operand word width in bits
package twoscomp_seq_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/twoscomp_seq_shreg.sv
// Operand/result registers and bit counter for twoscomp_seq.
// The operand is held unshifted so the full word stays available while the
// result is assembled bit by bit from the serial unit's response.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : latch din as the new operand and clear the bit counter
//   din        : operand word
//   shift_en   : one serial step; capture ser_out into result bit k
//   ser_out    : serial result bit from the external unit
//   ser_bit    : operand bit k, the current serial operand bit
//   operand    : latched operand word
//   result     : assembled result word
//   done       : asserted during the last serial step (k = WIDTH-1)
module twoscomp_seq_shreg
  import twoscomp_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  input  logic             ser_out,
  output logic             ser_bit,
  output logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  assign done    = shift_en && (cnt == LAST);
  assign ser_bit = operand[cnt];

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // reset is tested first inside the clocked block, making it synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      operand <= '0;
      result  <= '0;
      cnt     <= '0;
    end else if (load) begin
      operand <= din;
      cnt     <= '0;
    end else if (shift_en) begin
      result[cnt] <= ser_out;
      cnt         <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/twoscomp_seq.sv
// Word-level wrapper around an external bit-serial two's-complement unit.
// A request word is accepted, the serial unit is cleared for one cycle, the
// operand is streamed LSB first while the unit's same-cycle response is
// collected, and the negated word is presented with a valid/ready handshake.
// Optional feature: define TWOSCOMP_SEQ_OVF_EN to add the ovf output, which
// flags the most negative operand (its negation overflows).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_ready  : request handshake; din is the operand
//   ser_rst             : clear to the serial unit (reset or CLR state)
//   ser_in, ser_out     : serial operand bit out, serial result bit in
//   dout                : result word
//   out_valid, out_ready: result handshake
//   busy                : high in every state except IDLE
//   ovf                 : (TWOSCOMP_SEQ_OVF_EN only) overflow flag in DONE
module twoscomp_seq
  import twoscomp_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             ser_rst,
  output logic             ser_in,
  input  logic             ser_out,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef TWOSCOMP_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_t           state;
  logic             load;
  logic             shift_en;
  logic             ser_bit;
  logic             done;
  logic [WIDTH-1:0] operand;

  // Reset gates in_ready combinationally so no request is seen as accepted
  // while the block is held in reset.
  assign in_ready = (state == IDLE) && !reset;
  assign load     = in_ready && in_valid;
  assign shift_en = (state == SHIFT);
  assign ser_rst  = reset || (state == CLR);
  assign ser_in   = shift_en ? ser_bit : 1'b0;

  twoscomp_seq_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .din     (din),
    .shift_en(shift_en),
    .ser_out (ser_out),
    .ser_bit (ser_bit),
    .operand (operand),
    .result  (dout),
    .done    (done)
  );

`ifdef TWOSCOMP_SEQ_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef TWOSCOMP_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            state <= CLR;
            busy  <= 1'b1;
          end
        end
        CLR: begin
          state <= SHIFT;
        end
        SHIFT: begin
          if (done) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef TWOSCOMP_SEQ_OVF_EN
            ovf       <= (operand == MOST_NEG);
`endif
          end
        end
        DONE: begin
          // Handoff takes a full edge; IDLE then needs its own cycle before
          // the next accept, which fixes the accept spacing at WIDTH+3.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef TWOSCOMP_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
